// File: rtl/conv_burst_encoder_if.sv
// conv_burst_encoder_if: bit-stream input handshake, symbol tick and coded
// symbol output of the burst convolutional encoder.
//   master : bit source / symbol timing (drives bit_in, bit_valid, sym_tick)
//   slave  : encoder (drives bit_ready, conv_out, burst_active, underrun,
//            fifo_level)
interface conv_burst_encoder_if #(
  parameter int unsigned FIFO_DEPTH = 16
) ();
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic             sym_tick;
  logic [1:0]       conv_out;
  logic             burst_active;
  logic             underrun;
  logic [LVL_W-1:0] fifo_level;

  modport master (
    output bit_in, bit_valid, sym_tick,
    input  bit_ready, conv_out, burst_active, underrun, fifo_level
  );

  modport slave (
    input  bit_in, bit_valid, sym_tick,
    output bit_ready, conv_out, burst_active, underrun, fifo_level
  );
endinterface

// File: rtl/conv_burst_encoder.sv
// conv_burst_encoder: rate-1/2, K=3 convolutional encoder (G0=7, G1=5 octal)
// fed from a serial bit FIFO, framed into bursts of DATA_SYMS data symbols
// plus TAIL_SYMS trellis-terminating symbols, followed by REST_SYMS idle
// slots. The burst state advances once per sym_tick pulse.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-low reset
//   io_bus : slave side of conv_burst_encoder_if
//            bit_in/bit_valid/bit_ready : serial bit input handshake
//            sym_tick                   : last cycle of each symbol period
//            conv_out                   : coded symbol {c1,c0}
//            burst_active               : conv_out carries data or tail
//            underrun                   : data slot found the FIFO empty
//            fifo_level                 : FIFO occupancy
module conv_burst_encoder #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DATA_SYMS  = 30,
  parameter int unsigned TAIL_SYMS  = 2,
  parameter int unsigned REST_SYMS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  conv_burst_encoder_if.slave  io_bus
);

  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned MAX_SLOTS = (DATA_SYMS > REST_SYMS)
                                      ? ((DATA_SYMS > TAIL_SYMS) ? DATA_SYMS : TAIL_SYMS)
                                      : ((REST_SYMS > TAIL_SYMS) ? REST_SYMS : TAIL_SYMS);
  localparam int unsigned SLOT_W    = (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1;

  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_TAIL = 2'd1,
    ST_REST = 2'd2
  } state_t;

  state_t              r_state;
  logic [SLOT_W-1:0]   r_slot;
  logic [1:0]          r_s;        // {s1,s0}, s0 = most recent input bit
  logic [1:0]          r_conv;
  logic                r_burst;
  logic                r_underrun;

  logic [FIFO_DEPTH-1:0] r_mem;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_u;
  logic w_c1;
  logic w_c0;
  logic w_slot_last;

  // FIFO status from the registered level; a same-cycle write never feeds a pop
  assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = io_bus.bit_valid && !w_full;
  assign w_pop   = io_bus.sym_tick && (r_state == ST_DATA) && !w_empty;

  // Encoder input is zero for tail symbols and for underrun data slots
  assign w_u  = w_pop ? r_mem[r_rd_ptr] : 1'b0;
  assign w_c1 = w_u ^ r_s[0] ^ r_s[1];
  assign w_c0 = w_u ^ r_s[1];

  // Final slot of the current burst phase
  always_comb begin
    w_slot_last = 1'b0;
    case (r_state)
      ST_DATA: w_slot_last = (r_slot == SLOT_W'(DATA_SYMS - 1));
      ST_TAIL: w_slot_last = (r_slot == SLOT_W'(TAIL_SYMS - 1));
      ST_REST: w_slot_last = (r_slot == SLOT_W'(REST_SYMS - 1));
      default: w_slot_last = 1'b1;
    endcase
  end

  // FIFO storage; contents are don't-care until written, pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= io_bus.bit_in;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Burst framing FSM and registered symbol outputs, advanced per sym_tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_DATA;
      r_slot     <= '0;
      r_s        <= 2'b00;
      r_conv     <= 2'b00;
      r_burst    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (io_bus.sym_tick) begin
        r_slot <= w_slot_last ? '0 : r_slot + SLOT_W'(1);
        case (r_state)
          ST_DATA: begin
            r_conv     <= {w_c1, w_c0};
            r_burst    <= 1'b1;
            r_s        <= {r_s[0], w_u};
            r_underrun <= w_empty;
            if (w_slot_last) r_state <= ST_TAIL;
          end
          ST_TAIL: begin
            r_conv  <= {w_c1, w_c0};
            r_burst <= 1'b1;
            r_s     <= {r_s[0], w_u};
            if (w_slot_last) r_state <= ST_REST;
          end
          ST_REST: begin
            r_conv  <= 2'b00;
            r_burst <= 1'b0;
            r_s     <= 2'b00;
            if (w_slot_last) r_state <= ST_DATA;
          end
          default: begin
            r_state <= ST_DATA;
            r_slot  <= '0;
          end
        endcase
      end
    end
  end

  assign io_bus.bit_ready    = !w_full;
  assign io_bus.conv_out     = r_conv;
  assign io_bus.burst_active = r_burst;
  assign io_bus.underrun     = r_underrun;
  assign io_bus.fifo_level   = r_level;

endmodule

// File: tb/tb_conv_burst_encoder.sv
// Bench for conv_burst_encoder: a behavioural reference (bit queue + K=3
// encoder + 48-slot frame position) predicts every cycle's outputs into a
// scoreboard queue; table vectors and hand sequences add fixed expectations.
module tb_conv_burst_encoder;

  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned DATA_SYMS  = 30;
  localparam int unsigned TAIL_SYMS  = 2;
  localparam int unsigned REST_SYMS  = 16;
  localparam int unsigned PERIOD     = DATA_SYMS + TAIL_SYMS + REST_SYMS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_burst_encoder_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  conv_burst_encoder #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .DATA_SYMS (DATA_SYMS),
    .TAIL_SYMS (TAIL_SYMS),
    .REST_SYMS (REST_SYMS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(bus)
  );

  typedef struct packed {
    logic [1:0] conv;
    logic       ba;
    logic       under;
    logic [4:0] level;
    logic       ready;
  } exp_t;

  typedef struct packed {
    logic       b;
    logic [1:0] conv;
  } enc_vec_t;

  exp_t sb_q[$];

  // reference model state
  bit         mq[$];
  logic [1:0] ms;
  int         mp;
  logic [1:0] mconv;
  logic       mba;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    mq.delete();
    sb_q.delete();
    ms    = 2'b00;
    mp    = 0;
    mconv = 2'b00;
    mba   = 1'b0;
  endtask

  // One clock cycle: drive at negedge, predict, compare at the next negedge
  task automatic step(input logic v, input logic b, input logic t);
    exp_t e;
    logic u;
    logic mun;
    logic wr;
    bus.bit_valid = v;
    bus.bit_in    = b;
    bus.sym_tick  = t;
    wr  = v && (mq.size() < FIFO_DEPTH);
    mun = 1'b0;
    u   = 1'b0;
    if (t) begin
      if (mp < DATA_SYMS) begin
        if (mq.size() > 0) u = mq.pop_front();
        else mun = 1'b1;
      end
      if (mp < DATA_SYMS + TAIL_SYMS) begin
        mconv = {u ^ ms[0] ^ ms[1], u ^ ms[1]};
        ms    = {ms[0], u};
        mba   = 1'b1;
      end else begin
        mconv = 2'b00;
        mba   = 1'b0;
        ms    = 2'b00;
      end
      mp = (mp + 1) % PERIOD;
    end
    if (wr) mq.push_back(b);
    e.conv  = mconv;
    e.ba    = mba;
    e.under = mun;
    e.level = 5'(mq.size());
    e.ready = (mq.size() < FIFO_DEPTH);
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    chk("sb_conv_out",     int'(bus.conv_out),     int'(e.conv));
    chk("sb_burst_active", int'(bus.burst_active), int'(e.ba));
    chk("sb_underrun",     int'(bus.underrun),     int'(e.under));
    chk("sb_fifo_level",   int'(bus.fifo_level),   int'(e.level));
    chk("sb_bit_ready",    int'(bus.bit_ready),    int'(e.ready));
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any edge
  task automatic do_reset();
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    bus.sym_tick  = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_conv_out",     int'(bus.conv_out),     0);
    chk("rst_burst_active", int'(bus.burst_active), 0);
    chk("rst_underrun",     int'(bus.underrun),     0);
    chk("rst_fifo_level",   int'(bus.fifo_level),   0);
    chk("rst_bit_ready",    int'(bus.bit_ready),    1);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  enc_vec_t   enc_tbl[4];
  logic [1:0] tail_tbl[4];
  logic [1:0] slot_conv[49];

  initial begin
    enc_tbl[0] = '{b: 1'b1, conv: 2'b11};
    enc_tbl[1] = '{b: 1'b0, conv: 2'b10};
    enc_tbl[2] = '{b: 1'b1, conv: 2'b00};
    enc_tbl[3] = '{b: 1'b1, conv: 2'b01};
    tail_tbl[0] = 2'b11;
    tail_tbl[1] = 2'b01;
    tail_tbl[2] = 2'b01;
    tail_tbl[3] = 2'b11;

    reset         = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    bus.sym_tick  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset with bits queued, then first tick is data slot 0
    for (int i = 0; i < 5; i++) step(1'b1, 1'(i & 1), 1'b0);
    chk("queued_before_reset", int'(bus.fifo_level), 5);
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("first_tick_conv", int'(bus.conv_out), 3);
    chk("first_tick_ba",   int'(bus.burst_active), 1);

    // Encoding table: 1,0,1,1 -> 11,10,00,01
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, enc_tbl[i].b, 1'b0);
    chk("enc_level_full", int'(bus.fifo_level), 4);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1);
      chk("enc_conv",  int'(bus.conv_out),     int'(enc_tbl[i].conv));
      chk("enc_level", int'(bus.fifo_level),   3 - i);
      chk("enc_ba",    int'(bus.burst_active), 1);
    end

    // Tail and rest: 28 zeros then 1,1, 48 ticks, then slot 48 from s=00
    do_reset();
    for (int slot = 0; slot < 49; slot++) begin
      if (slot < 30) step(1'b1, (slot >= 28) ? 1'b1 : 1'b0, 1'b0);
      if (slot == 48) step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      slot_conv[slot] = bus.conv_out;
      if (slot >= 32 && slot < 48) begin
        chk("rest_conv", int'(bus.conv_out),     0);
        chk("rest_ba",   int'(bus.burst_active), 0);
      end
      if (slot < 32) chk("burst_ba", int'(bus.burst_active), 1);
    end
    for (int i = 0; i < 4; i++) chk("tail_conv", int'(slot_conv[28 + i]), int'(tail_tbl[i]));
    chk("slot48_conv", int'(slot_conv[48]), 3);
    chk("slot48_ba",   int'(bus.burst_active), 1);

    // Underrun: empty tick, then a write coinciding with a tick
    do_reset();
    step(1'b0, 1'b0, 1'b1);
    chk("under_pulse", int'(bus.underrun),   1);
    chk("under_conv",  int'(bus.conv_out),   0);
    chk("under_level", int'(bus.fifo_level), 0);
    step(1'b0, 1'b0, 1'b0);
    chk("under_one_cycle", int'(bus.underrun), 0);
    step(1'b1, 1'b1, 1'b1);
    chk("under_same_cycle_write", int'(bus.underrun),   1);
    chk("under_bit_kept",         int'(bus.fifo_level), 1);
    step(1'b0, 1'b0, 1'b1);
    chk("under_bit_used", int'(bus.conv_out), 3);
    chk("under_cleared",  int'(bus.underrun), 0);

    // Backpressure
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    chk("bp_level_full", int'(bus.fifo_level), 16);
    chk("bp_not_ready",  int'(bus.bit_ready),  0);
    step(1'b1, 1'b1, 1'b1);
    chk("bp_level_pop", int'(bus.fifo_level), 15);
    chk("bp_ready",     int'(bus.bit_ready),  1);
    step(1'b1, 1'b1, 1'b0);
    chk("bp_refill", int'(bus.fifo_level), 16);

    // Mid-burst reset at slot 10
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
    end
    chk("mid_ba_before_reset", int'(bus.burst_active), 1);
    do_reset();

    // Writes during REST accumulate with no pops
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("rest_write_level", int'(bus.fifo_level), k);
      step(1'b0, 1'b0, 1'b1);
      chk("rest_tick_level", int'(bus.fifo_level), k);
    end

    // Random traffic including back-to-back ticks
    do_reset();
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
